// File: rtl/pipe_id_stage.sv
// Instruction-decode stage: IF/ID register, decoder, 32-entry register file with
// same-cycle write-back bypass, load-use stall detection and the ID/EX register.
module pipe_id_stage #(
    parameter int DW = 32,
    parameter int RA = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] if_instr,
    input  logic [DW-1:0] if_pc,
    input  logic          if_valid,
    input  logic          flush,
    input  logic          wb_we,
    input  logic [RA-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          stall,
    output logic          id_valid,
    output logic [DW-1:0] id_pc,
    output logic [DW-1:0] id_rs_val,
    output logic [DW-1:0] id_rt_val,
    output logic [DW-1:0] id_imm,
    output logic [RA-1:0] id_rt,
    output logic [RA-1:0] id_dst,
    output logic [3:0]    id_alu_op,
    output logic          id_alu_src,
    output logic          id_reg_we,
    output logic          id_mem_rd,
    output logic          id_mem_wr,
    output logic          id_branch
);
    localparam int NREG = 2**RA;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc;
        logic [DW-1:0] rs_val;
        logic [DW-1:0] rt_val;
        logic [DW-1:0] imm;
        logic [RA-1:0] rt;
        logic [RA-1:0] dst;
        logic [3:0]    alu_op;
        logic          alu_src;
        logic          reg_we;
        logic          mem_rd;
        logic          mem_wr;
        logic          branch;
    } idex_t;

    logic          ifid_valid_q, ifid_valid_d;
    logic [DW-1:0] ifid_instr_q, ifid_instr_d;
    logic [DW-1:0] ifid_pc_q, ifid_pc_d;
    idex_t         idex_q, idex_d, dec;
    logic [DW-1:0] rf_q [NREG];
    logic [DW-1:0] rf_d [NREG];

    logic [5:0]    op;
    logic [RA-1:0] rs, rt, rd;
    logic          reads_rs, reads_rt;

    assign op = ifid_instr_q[31:26];
    assign rs = ifid_instr_q[25:21];
    assign rt = ifid_instr_q[20:16];
    assign rd = ifid_instr_q[15:11];

    // Decoder plus operand read; a write-back in flight this cycle wins over the array
    always_comb begin
        dec        = '0;
        reads_rs   = 1'b0;
        reads_rt   = 1'b0;
        dec.valid  = 1'b1;
        dec.pc     = ifid_pc_q;
        dec.imm    = {{(DW-16){ifid_instr_q[15]}}, ifid_instr_q[15:0]};
        dec.rt     = rt;
        case (op)
            6'h00: begin
                dec.dst    = rd;
                dec.alu_op = ifid_instr_q[3:0];
                dec.reg_we = 1'b1;
                reads_rs   = 1'b1;
                reads_rt   = 1'b1;
            end
            6'h11: begin
                dec.dst     = rt;
                dec.alu_src = 1'b1;
                dec.reg_we  = 1'b1;
                reads_rs    = 1'b1;
            end
            6'h23: begin
                dec.dst     = rt;
                dec.alu_src = 1'b1;
                dec.reg_we  = 1'b1;
                dec.mem_rd  = 1'b1;
                reads_rs    = 1'b1;
            end
            6'h2B: begin
                dec.alu_src = 1'b1;
                dec.mem_wr  = 1'b1;
                reads_rs    = 1'b1;
                reads_rt    = 1'b1;
            end
            6'h04: begin
                dec.branch = 1'b1;
                dec.alu_op = 4'd1;
                reads_rs   = 1'b1;
                reads_rt   = 1'b1;
            end
            default: ;
        endcase
        if (dec.dst == '0)
            dec.reg_we = 1'b0;

        if (rs == '0)                      dec.rs_val = '0;
        else if (wb_we && wb_addr == rs)   dec.rs_val = wb_data;
        else                               dec.rs_val = rf_q[rs];
        if (rt == '0)                      dec.rt_val = '0;
        else if (wb_we && wb_addr == rt)   dec.rt_val = wb_data;
        else                               dec.rt_val = rf_q[rt];
    end

    // Load in ID/EX whose result the IF/ID instruction needs; a flush overrides it
    assign stall = !flush && ifid_valid_q && idex_q.valid && idex_q.mem_rd &&
                   (idex_q.dst != '0) &&
                   ((reads_rs && rs == idex_q.dst) || (reads_rt && rt == idex_q.dst));

    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        idex_d       = '0;
        if (flush) begin
            ifid_valid_d = 1'b0;
        end else if (!stall) begin
            ifid_valid_d = if_valid;
            ifid_instr_d = if_instr;
            ifid_pc_d    = if_pc;
            if (ifid_valid_q)
                idex_d = dec;
        end
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_we && wb_addr != '0)
            rf_d[wb_addr] = wb_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
            idex_q       <= '0;
            for (int i = 0; i < NREG; i++)
                rf_q[i] <= '0;
        end else begin
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            idex_q       <= idex_d;
            rf_q         <= rf_d;
        end
    end

    assign id_valid   = idex_q.valid;
    assign id_pc      = idex_q.pc;
    assign id_rs_val  = idex_q.rs_val;
    assign id_rt_val  = idex_q.rt_val;
    assign id_imm     = idex_q.imm;
    assign id_rt      = idex_q.rt;
    assign id_dst     = idex_q.dst;
    assign id_alu_op  = idex_q.alu_op;
    assign id_alu_src = idex_q.alu_src;
    assign id_reg_we  = idex_q.reg_we;
    assign id_mem_rd  = idex_q.mem_rd;
    assign id_mem_wr  = idex_q.mem_wr;
    assign id_branch  = idex_q.branch;

endmodule
